peripheral_arbiter_wb: RTL
==========================

# peripheral_arbiter_wb

Round-robin Wishbone B3 arbiter that shares one Wishbone slave (the peripheral memory `peripheral_design`) between `NUM_MASTERS` bus masters. The grant is held for the whole bus cycle, classic or burst, until the owner drops `cyc`. A watchdog terminates a stalled transfer with `err`. The block sits between the master BFMs/cores and the single slave port in the Wishbone application testbench.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters, 2..16.
- `TIMEOUT`, 64: cycles a granted master may hold `stb` without slave `ack`/`err` before the watchdog fires; 0 disables the watchdog.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_adr_i`, `m_dat_i` in `NUM_MASTERS*32`: per-master address and write data, packed; master i occupies `[32*i +: 32]`.
- `m_sel_i` in `NUM_MASTERS*4`; `m_bte_i` in `NUM_MASTERS*2`; `m_cti_i` in `NUM_MASTERS*3`: per-master byte selects, BTE and CTI, packed the same way.
- `m_we_i`, `m_cyc_i`, `m_stb_i` in `NUM_MASTERS`: per-master control.
- `m_ack_o`, `m_err_o` out `NUM_MASTERS`: slave `ack`/`err` routed to the owner only. The watchdog error is ORed into `m_err_o`.
- `m_dat_o` out 32: slave read data, broadcast to all masters.
- `s_adr_o`, `s_dat_o` out 32; `s_sel_o` out 4; `s_we_o` out 1; `s_bte_o` out 2; `s_cti_o` out 3; `s_cyc_o`, `s_stb_o` out 1: muxed owner signals to the slave.
- `s_ack_i`, `s_err_i` in 1; `s_dat_i` in 32: slave response.
- `grant_o` out `NUM_MASTERS`: one-hot current owner, or all-zero.
- `busy_o` out 1: high in state OWNED.

## Operation
- **FSM states:** IDLE, OWNED.
- **Reset values:** state IDLE, `grant_o`=0, priority pointer = `NUM_MASTERS-1` (master 0 wins first), watchdog counter 0.
- **Effect of reset on outputs:** `s_cyc_o`, `s_stb_o`, `s_we_o`, all `m_ack_o`/`m_err_o` and `busy_o` are 0 from the first edge with `rst` high.
- **IDLE:**
  - If any `m_cyc_i` is high, select the first requester searching from pointer+1 upward, with wrap-around.
  - Register the winner into `grant_o`, set the pointer to the winner, go to OWNED.
  - Otherwise stay in IDLE.
- **OWNED, slave-side muxing:**
  - All slave-side outputs equal the owner's inputs.
  - `s_cyc_o`/`s_stb_o` are gated by `m_cyc_i[owner]`.
  - Non-owners see `ack`=`err`=0.
- **OWNED, release:** when `m_cyc_i[owner]` is sampled low, return to IDLE with `grant_o`=0. There is no mid-cycle preemption, including during CTI 001/010 bursts.
- **Mandatory dead cycle:** exactly one idle cycle between owners. This is required so the slave's registered `cyc&stb` drops and its next access is decoded as a new cycle, not a burst continuation.
- **Watchdog:**
  - In OWNED, the counter increments each cycle `s_stb_o`=1 with `s_ack_i`=`s_err_i`=0, and clears otherwise.
  - On reaching `TIMEOUT`: pulse `m_err_o[owner]` for one cycle, force `s_cyc_o`/`s_stb_o` low, and go to IDLE.
  - The owner must drop `cyc` after `err`.
  - Counter width is `$clog2(TIMEOUT+1)`, saturating (never wraps).
- **Slave error:** `s_err_i` is passed through only; it does not release the grant.

## Timing
- **Grant latency:** a request sampled in IDLE at edge k gives `grant_o`/`s_cyc_o` valid from edge k+1. Classic slave `ack` then arrives at edge k+2.
- **Release latency:** owner `cyc` sampled low at edge j gives IDLE from edge j. The next owner's `s_cyc_o` is earliest at edge j+1.
- **Simultaneous requests in IDLE:** strict rotation from the pointer.
- **Owner drops `cyc` while others request:** IDLE for one cycle, then the next in rotation is granted.
- **Watchdog fires in the same cycle the slave acks:** the `ack` wins and the counter clears.
- **Reset mid-burst:** the grant is lost at the reset edge, with no ack/err pulse produced.
- All response paths (`ack`/`err`/`dat`) are combinational from slave to master, adding zero latency.

## Structure
- **Package `peripheral_arbiter_wb_pkg`:**
  - CTI constants: CLASSIC 000, CONST_BURST 001, INC_BURST 010, END_OF_BURST 111.
  - BTE constants: LINEAR, WRAP_4, WRAP_8, WRAP_16.
  - State enum `arb_state_t` {IDLE, OWNED}.
- **Sub-module `peripheral_arbiter_rr`:** combinational round-robin picker. Inputs are the request vector and pointer; outputs are the one-hot winner and its index. It is reusable by other shared-resource controllers.
- **Top level:** FSM, muxes, watchdog.

## Test plan
- **Single classic access:** master 2 writes 0xDEADBEEF to 0x10, sel 0xF → `grant_o`=0100 at k+1, `m_ack_o[2]` at k+2. A later classic read of 0x10 returns 0xDEADBEEF.
- **Rotation:** masters 0..3 all request continuously, each doing one classic access → grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- **Burst lock:** master 1 runs an INC_BURST of 4 words (LINEAR, 0x20..0x2C, last beat CTI 111) while master 3 requests → master 3 is not granted until one cycle after master 1 drops `cyc`. Memory at 0x20..0x2C holds the four words.
- **Watchdog:** `TIMEOUT`=8, and the slave `ack` is forced low for master 0 → `m_err_o[0]` pulses 8 cycles after `stb`, then `s_cyc_o`=0 and `busy_o`=0 on the next cycle.
- **Reset mid-burst:** `rst` is asserted on beat 2 of a WRAP_4 burst → at the reset edge `s_cyc_o`=0 and `grant_o`=0. After reset release, master 0 wins first.
- **Slave error pass-through:** access to 0x400 (beyond `MEMORY_SIZE`) → the slave error reaches only the owner's `m_err_o`, and the grant persists until `cyc` drops.

Source files
------------

// File: rtl/peripheral_arbiter_wb_pkg.sv
// Shared Wishbone B3 encodings and arbiter state type for the peripheral arbiter.
package peripheral_arbiter_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
  localparam logic [2:0] CTI_INC_BURST    = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP_4  = 2'b01;
  localparam logic [1:0] BTE_WRAP_8  = 2'b10;
  localparam logic [1:0] BTE_WRAP_16 = 2'b11;

  typedef enum logic {IDLE, OWNED} arb_state_t;

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, with wrap.
module peripheral_arbiter_rr #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx
);

  // Scan from the farthest offset down so the nearest requester is assigned last.
  always_comb begin
    int idx;
    win     = '0;
    win_idx = '0;
    idx     = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter sharing one slave among NUM_MASTERS masters,
// holding the grant for a whole bus cycle and aborting stalled transfers.
module peripheral_arbiter_wb
  import peripheral_arbiter_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               m_dat_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [1:0]                s_bte_o,
  output logic [2:0]                s_cti_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic [31:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      busy_o
);

  localparam int   IDX_W   = $clog2(NUM_MASTERS);
  localparam int   CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] wd_cnt;

  logic [NUM_MASTERS-1:0] win;
  logic [IDX_W-1:0]       win_idx;
  logic                   owned, own_cyc, own_stb, stall, wd_fire;

  peripheral_arbiter_rr #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
    .req    (m_cyc_i),
    .ptr    (ptr),
    .win    (win),
    .win_idx(win_idx)
  );

  // While OWNED the pointer doubles as the owner index.
  assign owned   = (state == OWNED);
  assign own_cyc = owned && m_cyc_i[ptr];
  assign own_stb = own_cyc && m_stb_i[ptr];
  assign stall   = own_stb && !s_ack_i && !s_err_i;
  assign wd_fire = WD_EN && stall && (wd_cnt == CNT_FIRE);

  assign s_adr_o = m_adr_i[32*ptr +: 32];
  assign s_dat_o = m_dat_i[32*ptr +: 32];
  assign s_sel_o = m_sel_i[4*ptr +: 4];
  assign s_bte_o = m_bte_i[2*ptr +: 2];
  assign s_cti_o = m_cti_i[3*ptr +: 3];
  assign s_we_o  = owned && m_we_i[ptr];
  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_stb;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant_o & {NUM_MASTERS{s_err_i | wd_fire}};
  assign busy_o  = owned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc_i) begin
            grant_o <= win;
            ptr     <= win_idx;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!m_cyc_i[ptr] || wd_fire) begin
            state   <= IDLE;
            grant_o <= '0;
            wd_cnt  <= '0;
          end else if (stall) begin
            if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
